// File: rtl/wshb_fb_pkg.sv
// Shared types and constants for the Wishbone test-pattern framebuffer slave.
package wshb_fb_pkg;

  typedef enum logic [1:0] {
    PAT_GRID  = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_SOLID = 2'd2,
    PAT_CHECK = 2'd3
  } pat_mode_e;

  localparam logic [23:0] WHITE = 24'hFF_FFFF;
  localparam logic [23:0] BLACK = 24'h00_0000;

  // CTRL register layout: [25:24] pattern mode, [23:0] solid colour
  localparam int CTRL_MODE_LSB  = 24;
  localparam int CTRL_MODE_MSB  = 25;
  localparam int CTRL_COLOR_LSB = 0;
  localparam int CTRL_COLOR_MSB = 23;
  localparam logic [23:0] CTRL_COLOR_RST = WHITE;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/fb_pattern_gen.sv
// Combinational test-pattern generator: pixel position, mode and colour -> 24-bit RGB.
// Needs XW >= 8 (bars use x[7:5]) and YW >= 5 (checker uses y[4]).
module fb_pattern_gen
  import wshb_fb_pkg::*;
#(
  parameter int XW = 10,
  parameter int YW = 9
) (
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  pat_mode_e     mode,
  input  logic [23:0]   color,
  output logic [23:0]   rgb
);

  logic [2:0] bar;
  logic       unused_hi;

  assign bar       = x[7:5];
  assign unused_hi = ^{x, y};

  // Select the pixel colour for the active pattern
  always_comb begin
    rgb = BLACK;
    case (mode)
      PAT_GRID:  if (x[3:0] == 4'd0 || y[3:0] == 4'd0) rgb = WHITE;
      PAT_BARS:  rgb = {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
      PAT_SOLID: rgb = color;
      PAT_CHECK: if (x[4] ^ y[4]) rgb = WHITE;
      default:   rgb = BLACK;
    endcase
  end

endmodule

// File: rtl/wshb_fb_slave.sv
// Wishbone classic slave that synthesises framebuffer pixels from a test pattern.
// Word index N = HDISP*VDISP is the CTRL register; sequential reads track raster x/y.
// Optional macro WSHB_RAND_WAIT_EN adds 0..3 pseudo-random wait cycles per transfer.
module wshb_fb_slave
  import wshb_fb_pkg::*;
#(
  parameter int HDISP       = 800,
  parameter int VDISP       = 480,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cyc,
  input  logic        stb,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [3:0]  sel,
  input  logic [31:0] dat_ms,
  input  logic [2:0]  cti,
  input  logic [1:0]  bte,
  output logic [31:0] dat_sm,
  output logic        ack,
  output logic        err,
  output logic        rty
);

  localparam int XW = $clog2(HDISP);
  localparam int YW = $clog2(VDISP);
  localparam int N  = HDISP * VDISP;
  localparam logic [29:0]   N_IDX   = 30'(N);
  localparam logic [XW-1:0] X_LAST  = XW'(HDISP - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(VDISP - 1);
  localparam logic [4:0]    WS_LOAD = 5'(WAIT_STATES);

  fsm_state_e    state, state_nxt;
  logic [4:0]    cnt, cnt_nxt, cnt_load;
  logic [31:0]   req_adr, req_dat;
  logic          req_we;
  logic [3:0]    req_sel;
  logic [31:0]   cur_adr, cur_dat;
  logic          cur_we;
  logic [3:0]    cur_sel;
  logic [29:0]   idx;
  logic [XW-1:0] x, x_nxt, px;
  logic [YW-1:0] y, y_nxt, py;
  logic [31:0]   seq_idx, seq_nxt;
  pat_mode_e     ctrl_mode, mode_nxt;
  logic [23:0]   ctrl_color, color_nxt;
  logic [23:0]   rgb;
  logic          accept, do_resp, resp_ok;
  logic [31:0]   resp_dat;
  logic          unused_top;

  assign rty        = 1'b0;
  assign accept     = (state == ST_IDLE) && cyc && stb;
  // With zero wait cycles the response is decided from the live bus in the accept cycle
  assign cur_adr    = (state == ST_IDLE) ? adr    : req_adr;
  assign cur_dat    = (state == ST_IDLE) ? dat_ms : req_dat;
  assign cur_we     = (state == ST_IDLE) ? we     : req_we;
  assign cur_sel    = (state == ST_IDLE) ? sel    : req_sel;
  assign idx        = cur_adr[31:2];
  assign px         = (idx == 30'd0) ? '0 : x;
  assign py         = (idx == 30'd0) ? '0 : y;
  assign unused_top = ^{cti, bte, cur_adr[1:0], cur_dat[31:26]};

`ifdef WSHB_RAND_WAIT_EN
  logic [7:0] lfsr;

  // Free-running Fibonacci LFSR, taps 8,6,5,4
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= 8'hA5;
    else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign cnt_load = WS_LOAD + {3'b000, lfsr[1:0]};
`else
  assign cnt_load = WS_LOAD;
`endif

  fb_pattern_gen #(.XW(XW), .YW(YW)) u_pat (
    .x     (px),
    .y     (py),
    .mode  (ctrl_mode),
    .color (ctrl_color),
    .rgb   (rgb)
  );

  // FSM state and wait-counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: count down the wait cycles, abort if the master drops cyc
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    do_resp   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (cnt_load == 5'd0) begin
            state_nxt = ST_RESP;
            do_resp   = 1'b1;
          end else begin
            state_nxt = ST_WAIT;
            cnt_nxt   = cnt_load;
          end
        end
      end
      ST_WAIT: begin
        if (!cyc) begin
          state_nxt = ST_IDLE;
        end else if (cnt == 5'd1) begin
          state_nxt = ST_RESP;
          cnt_nxt   = 5'd0;
          do_resp   = 1'b1;
        end else begin
          cnt_nxt = cnt - 5'd1;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Address decode and response / register update values
  always_comb begin
    resp_ok   = 1'b0;
    resp_dat  = 32'd0;
    x_nxt     = x;
    y_nxt     = y;
    seq_nxt   = seq_idx;
    mode_nxt  = ctrl_mode;
    color_nxt = ctrl_color;
    if (idx == N_IDX) begin
      resp_ok = 1'b1;
      if (cur_we) begin
        if (cur_sel[0]) color_nxt[7:0]   = cur_dat[7:0];
        if (cur_sel[1]) color_nxt[15:8]  = cur_dat[15:8];
        if (cur_sel[2]) color_nxt[23:16] = cur_dat[CTRL_COLOR_MSB:16];
        if (cur_sel[3]) mode_nxt = pat_mode_e'(cur_dat[CTRL_MODE_MSB:CTRL_MODE_LSB]);
      end else begin
        resp_dat = {6'b0, ctrl_mode, ctrl_color[CTRL_COLOR_MSB:CTRL_COLOR_LSB]};
      end
    end else if (!cur_we && idx < N_IDX) begin
      if (idx == 30'd0 || {2'b00, idx} == seq_idx) begin
        resp_ok  = 1'b1;
        resp_dat = {8'h00, rgb};
        if (px == X_LAST) begin
          x_nxt = '0;
          y_nxt = (py == Y_LAST) ? '0 : py + 1'b1;
        end else begin
          x_nxt = px + 1'b1;
          y_nxt = py;
        end
        seq_nxt = (idx == N_IDX - 30'd1) ? 32'd0 : {2'b00, idx} + 32'd1;
      end
    end
  end

  // Capture the request so it stays stable across wait cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_adr <= '0;
      req_dat <= '0;
      req_we  <= 1'b0;
      req_sel <= '0;
    end else if (accept) begin
      req_adr <= adr;
      req_dat <= dat_ms;
      req_we  <= we;
      req_sel <= sel;
    end
  end

  // Registered response pulse plus raster / CTRL state, committed only on ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack        <= 1'b0;
      err        <= 1'b0;
      dat_sm     <= '0;
      x          <= '0;
      y          <= '0;
      seq_idx    <= '0;
      ctrl_mode  <= PAT_GRID;
      ctrl_color <= CTRL_COLOR_RST;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      if (do_resp) begin
        ack    <= resp_ok;
        err    <= !resp_ok;
        dat_sm <= resp_ok ? resp_dat : 32'd0;
        if (resp_ok) begin
          x          <= x_nxt;
          y          <= y_nxt;
          seq_idx    <= seq_nxt;
          ctrl_mode  <= mode_nxt;
          ctrl_color <= color_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_wshb_fb_slave.sv
// Self-checking bench for wshb_fb_slave: vector table plus directed multi-cycle sequences.
module tb_wshb_fb_slave;

  localparam int HD = 256;
  localparam int VD = 20;
  localparam int WS = 1;
  localparam int N  = HD * VD;
  localparam logic [31:0] CTRL_ADR = 32'(N * 4);

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [31:0] adr, dat_ms, dat_sm;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack, err, rty;

  always #5 clk = ~clk;

  wshb_fb_slave #(.HDISP(HD), .VDISP(VD), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst), .cyc(cyc), .stb(stb), .we(we), .adr(adr), .sel(sel),
    .dat_ms(dat_ms), .cti(cti), .bte(bte), .dat_sm(dat_sm), .ack(ack), .err(err), .rty(rty)
  );

  typedef struct {
    logic        is_err;
    logic        chk_dat;
    logic [31:0] dat;
  } exp_t;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
    logic        e_err;
    logic [31:0] e_dat;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[20];
  int   n_pass = 0;
  int   n_total = 0;
  int   n_ack = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Independent arithmetic model of the four test patterns
  function automatic logic [31:0] exp_pix(input int px, input int py, input int m, input logic [23:0] c);
    int bar;
    logic [23:0] v;
    bar = (px / 32) % 8;
    case (m)
      0: v = ((px % 16) == 0 || (py % 16) == 0) ? 24'hFFFFFF : 24'h0;
      1: v = {((bar & 4) != 0) ? 8'hFF : 8'h00, ((bar & 2) != 0) ? 8'hFF : 8'h00,
              ((bar & 1) != 0) ? 8'hFF : 8'h00};
      2: v = c;
      default: v = ((((px / 16) % 2) ^ ((py / 16) % 2)) != 0) ? 24'hFFFFFF : 24'h0;
    endcase
    return {8'h00, v};
  endfunction

  // Drive one transfer, wait (bounded) for ack/err, compare against the scoreboard head
  task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, input string name);
    exp_t e;
    logic seen;
    int   lat;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_ms = d;
    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (ack || err) seen = 1'b1;
    end
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL %s: scoreboard empty at response", name);
    end else begin
      e = sb.pop_front();
      if (!seen) begin
        n_total++;
        $display("FAIL %s: no ack/err within %0d cycles", name, lat);
      end else begin
        if (ack) n_ack++;
        if (err) n_err++;
        check({name, " err"}, 32'(err), 32'(e.is_err));
        check({name, " ack"}, 32'(ack), 32'(!e.is_err));
        if (e.chk_dat) check({name, " dat"}, dat_sm, e.dat);
`ifdef WSHB_RAND_WAIT_EN
        n_total++;
        if (lat >= 2 && lat <= 5) n_pass++;
        else $display("FAIL %s latency: got %0d expected 2..5", name, lat);
`else
        check({name, " latency"}, 32'(lat), 32'(2 + WS - 1));
`endif
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    if (seen) check({name, " pulse"}, {30'd0, ack, err}, 32'd0);
  endtask

  task automatic rd(input logic [31:0] a, input logic e_err, input logic [31:0] e_dat, input string name);
    sb.push_back('{is_err: e_err, chk_dat: !e_err, dat: e_dat});
    xfer(1'b0, a, 4'h0, 32'h0, name);
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                    input logic e_err, input string name);
    sb.push_back('{is_err: e_err, chk_dat: 1'b0, dat: 32'h0});
    xfer(1'b1, a, s, d, name);
  endtask

  initial begin
    int ack0;
    tbl[0]  = '{1'b0, 32'h0000,  4'h0, 32'h0,        1'b0, 32'h00FFFFFF};
    tbl[1]  = '{1'b0, 32'h0004,  4'h0, 32'h0,        1'b0, 32'h00FFFFFF};
    tbl[2]  = '{1'b0, 32'h0008,  4'h0, 32'h0,        1'b0, 32'h00FFFFFF};
    tbl[3]  = '{1'b0, 32'h0040,  4'h0, 32'h0,        1'b1, 32'h0};
    tbl[4]  = '{1'b0, 32'h000C,  4'h0, 32'h0,        1'b0, 32'h00FFFFFF};
    tbl[5]  = '{1'b1, 32'h0010,  4'hF, 32'h11223344, 1'b1, 32'h0};
    tbl[6]  = '{1'b0, CTRL_ADR + 32'd4, 4'h0, 32'h0, 1'b1, 32'h0};
    tbl[7]  = '{1'b0, CTRL_ADR,  4'h0, 32'h0,        1'b0, 32'h00FFFFFF};
    tbl[8]  = '{1'b1, CTRL_ADR,  4'hF, 32'h02123456, 1'b0, 32'h0};
    tbl[9]  = '{1'b0, CTRL_ADR,  4'h0, 32'h0,        1'b0, 32'h02123456};
    tbl[10] = '{1'b0, 32'h0010,  4'h0, 32'h0,        1'b0, 32'h00123456};
    tbl[11] = '{1'b1, CTRL_ADR,  4'h1, 32'h000000AA, 1'b0, 32'h0};
    tbl[12] = '{1'b0, CTRL_ADR,  4'h0, 32'h0,        1'b0, 32'h021234AA};
    tbl[13] = '{1'b1, CTRL_ADR,  4'h0, 32'hFFFFFFFF, 1'b0, 32'h0};
    tbl[14] = '{1'b0, CTRL_ADR,  4'h0, 32'h0,        1'b0, 32'h021234AA};
    tbl[15] = '{1'b1, CTRL_ADR,  4'h8, 32'h01000000, 1'b0, 32'h0};
    tbl[16] = '{1'b0, 32'h0014,  4'h0, 32'h0,        1'b0, 32'h00000000};
    tbl[17] = '{1'b1, CTRL_ADR,  4'h8, 32'h03000000, 1'b0, 32'h0};
    tbl[18] = '{1'b0, 32'h0018,  4'h0, 32'h0,        1'b0, 32'h00000000};
    tbl[19] = '{1'b1, CTRL_ADR,  4'h8, 32'h00000000, 1'b0, 32'h0};

    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; sel = '0; dat_ms = '0;
    cti = 3'b000; bte = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("reset ack", 32'(ack), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset dat_sm", dat_sm, 32'd0);
    check("rty tied", 32'(rty), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 20; k++) begin
      sb.push_back('{is_err: tbl[k].e_err, chk_dat: !tbl[k].w && !tbl[k].e_err, dat: tbl[k].e_dat});
      xfer(tbl[k].w, tbl[k].a, tbl[k].s, tbl[k].d, $sformatf("vec%0d", k));
    end

    // Full frame in grid mode, then wrap back to pixel (0,0)
    ack0 = n_ack;
    n_err = 0;
    for (int i = 0; i < N; i++) rd(32'(i * 4), 1'b0, exp_pix(i % HD, i / HD, 0, 24'h0), "frame");
    check("frame acks", 32'(n_ack - ack0), 32'(N));
    check("frame errs", 32'(n_err), 32'd0);
    rd(32'h0, 1'b0, 32'h00FFFFFF, "wrap pix00");
    rd(32'h4, 1'b0, 32'h00FFFFFF, "wrap pix10");

    // One line of colour bars
    wr(CTRL_ADR, 4'h8, 32'h01000000, 1'b0, "mode bars");
    for (int i = 0; i < HD; i++) rd(32'(i * 4), 1'b0, exp_pix(i, 0, 1, 24'h0), "bars");

    // Checker over enough lines to cross y[4]
    wr(CTRL_ADR, 4'h8, 32'h03000000, 1'b0, "mode check");
    for (int i = 0; i < 17 * HD; i++) rd(32'(i * 4), 1'b0, exp_pix(i % HD, i / HD, 3, 24'h0), "checker");
    wr(CTRL_ADR, 4'h8, 32'h00000000, 1'b0, "mode grid");

    // Abort during WAIT: no response, sequence index untouched
    rd(32'h0, 1'b0, 32'h00FFFFFF, "pre-abort");
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h4;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("abort quiet", {30'd0, ack, err}, 32'd0);
    end
    rd(32'h4, 1'b0, 32'h00FFFFFF, "post-abort");

    // Reset while in WAIT
    wr(CTRL_ADR, 4'h8, 32'h02000000, 1'b0, "mode solid");
    rd(32'h0, 1'b0, 32'h001234AA, "solid pix");
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h4;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst-in-wait ack/err", {30'd0, ack, err}, 32'd0);
    check("rst-in-wait dat_sm", dat_sm, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    check("rst hold ack/err", {30'd0, ack, err}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    rd(CTRL_ADR, 1'b0, 32'h00FFFFFF, "ctrl after rst");
    rd(32'h4, 1'b1, 32'h0, "seq after rst");
    rd(32'h0, 1'b0, 32'h00FFFFFF, "pix00 after rst");

`ifdef WSHB_RAND_WAIT_EN
    for (int k = 0; k < 1000; k++) rd(32'h0, 1'b0, 32'h00FFFFFF, "rand wait");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
